// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue controller.
package div_pkg;
  localparam logic [5:0] DIV_CONTROL  = 6'b011010;
  localparam logic [5:0] DIVU_CONTROL = 6'b011011;

  // Divider result layout: {remainder, quotient}
  localparam int RES_HI_MSB = 63;
  localparam int RES_HI_LSB = 32;
  localparam int RES_LO_MSB = 31;
  localparam int RES_LO_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_ABORT
  } div_state_e;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction
endpackage

// File: rtl/div_issue_ctrl_if.sv
// Start/annul handshake and operand/result bus between the controller and the iterative divider.
interface div_issue_ctrl_if;
  logic [5:0]  op;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  modport master (output op, opdata1, opdata2, start, annul, input result, ready);
  modport slave  (input op, opdata1, opdata2, start, annul, output result, ready);
endinterface

// File: rtl/div_fastpath_detect.sv
// Combinational classifier for divides whose result is known without iterating.
module div_fastpath_detect
  import div_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        hit,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic rt_one, rs_zero;

  assign rt_one  = (rt == 32'd1);
  assign rs_zero = (rs == 32'd0) && (rt != 32'd0);
  assign hit     = is_div_op(op) && (rt_one || rs_zero);
  // x/1 = x with no remainder regardless of signedness; 0/x = 0 rem 0
  assign lo      = rt_one ? rs : 32'd0;
  assign hi      = 32'd0;
endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback sequencer for the iterative divider.
// Optional DIV_FASTPATH_EN: skip the divider for rt==1 and rs==0 divides.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [5:0]        req_op_i,
  input  logic [31:0]       req_rs_i,
  input  logic [31:0]       req_rt_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              hilo_we_o,
  output logic [31:0]       hi_o,
  output logic [31:0]       lo_o,
  div_issue_ctrl_if.master  div
);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  div_state_e  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        start_q, start_d, annul_q, annul_d;
  logic [DW-1:0] drain_q, drain_d;
  logic        accept;
  logic        fast_hit;
  logic [31:0] fast_hi, fast_lo;

`ifdef DIV_FASTPATH_EN
  div_fastpath_detect u_fast (
    .op  (req_op_i),
    .rs  (req_rs_i),
    .rt  (req_rt_i),
    .hit (fast_hit),
    .hi  (fast_hi),
    .lo  (fast_lo)
  );
`else
  assign fast_hit = 1'b0;
  assign fast_hi  = 32'd0;
  assign fast_lo  = 32'd0;
`endif

  assign accept = (state_q == S_IDLE) && req_valid_i && is_div_op(req_op_i) && !flush_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start_d = start_q;
    annul_d = annul_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d = req_op_i;
        rs_d = req_rs_i;
        rt_d = req_rt_i;
        if (fast_hit) begin
          hi_d    = fast_hi;
          lo_d    = fast_lo;
          state_d = S_WB;
        end else begin
          // start rises with ISSUE so the divider samples it at the end of ISSUE
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          drain_d = DW'(DRAIN_CYCLES);
          state_d = S_ABORT;
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end else if (div.ready) begin
          hi_d    = div.result[RES_HI_MSB:RES_HI_LSB];
          lo_d    = div.result[RES_LO_MSB:RES_LO_LSB];
          start_d = 1'b0;
          state_d = S_WB;
        end
      end
      S_WB: state_d = S_IDLE;
      S_ABORT: begin
        if (drain_q <= DW'(1)) begin
          annul_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      start_q <= start_d;
      annul_q <= annul_d;
      drain_q <= drain_d;
    end
  end

  assign stall_o     = accept || (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_ABORT);
  assign busy_o      = (state_q != S_IDLE);
  assign hilo_we_o   = (state_q == S_WB);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div.op      = op_q;
  assign div.opdata1 = rs_q;
  assign div.opdata2 = rt_q;
  assign div.start   = start_q;
  assign div.annul   = annul_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 32-clock iterative divider.
module tb_div_issue_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_op = '0;
  logic [31:0] req_rs = '0, req_rt = '0;
  logic        flush = 1'b0;
  logic        stall, busy, hilo_we;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  div_issue_ctrl_if dif ();

  div_issue_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_op_i    (req_op),
    .req_rs_i    (req_rs),
    .req_rt_i    (req_rt),
    .flush_i     (flush),
    .stall_o     (stall),
    .busy_o      (busy),
    .hilo_we_o   (hilo_we),
    .hi_o        (hi),
    .lo_o        (lo),
    .div         (dif)
  );

  // Divider model: result in cycle start+35 (start+4 for divisor 0), held until start drops
  function automatic logic [63:0] div_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (op == DIVU_CONTROL) return {a % b, a / b};
    sa = a; sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  int dcnt;
  always @(posedge clk) begin
    if (rst || !dif.start) begin
      dcnt      <= 0;
      dif.ready <= 1'b0;
    end else if (!dif.ready) begin
      if (dcnt == ((dif.opdata2 == 32'd0) ? 3 : 34)) begin
        dif.ready  <= 1'b1;
        dif.result <= div_model(dif.op, dif.opdata1, dif.opdata2);
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  int we_cnt, annul_cnt, start_cnt;
  always @(posedge clk) begin
    if (hilo_we)   we_cnt++;
    if (dif.annul) annul_cnt++;
    if (dif.start) start_cnt++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    we_cnt = 0; annul_cnt = 0; start_cnt = 0;
  endtask

  task automatic accept_req(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
    #1;
  endtask

  // Full divide: accept, track latency to the HI/LO write, check results and single strobe
  task automatic run_div(input string tag, input logic [5:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
    int  lat;
    bit  stall_ok;
    clr_mon();
    accept_req(op, rs, rt);
    chk({tag, "_stall_acc"}, stall, 1);
    step();
    req_valid = 1'b0;
    lat = 1; stall_ok = 1;
    while (!hilo_we && lat < 100) begin
      if (!stall) stall_ok = 0;
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall_hold"}, stall_ok, 1);
    chk({tag, "_stall_wb"}, stall, 0);
    chk({tag, "_start_wb"}, dif.start, 0);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    step();
    chk({tag, "_we_once"}, we_cnt, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  int fast_lat;
  int g;

  initial begin
`ifdef DIV_FASTPATH_EN
    fast_lat = 1;
`else
    fast_lat = 37;
`endif
    rst = 1'b1;
    step(); step();
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_start_annul", {dif.start, dif.annul}, 2'b00);
    chk("rst_operands", {dif.op, dif.opdata1, dif.opdata2}, 64'd0);
    rst = 1'b0;
    step();

    // Non-divide op is ignored
    accept_req(6'h20, 32'd100, 32'd7);
    chk("bad_op_stall", stall, 0);
    step();
    chk("bad_op_busy", busy, 0);
    req_valid = 1'b0;
    step();

    run_div("divu_100_7", DIVU_CONTROL, 32'd100, 32'd7, 32'd14, 32'd2, 37);
    run_div("div_m7_2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 37);
    run_div("div_5_0", DIV_CONTROL, 32'd5, 32'd0, 32'd0, 32'd0, 6);

    // Flush 10 cycles into a divide: annul for 2 cycles, no write
    clr_mon();
    accept_req(DIVU_CONTROL, 32'd100, 32'd7);
    step();
    req_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_abort", {busy, stall, dif.start, dif.annul}, 4'b1101);
    step();
    chk("flush_annul2", dif.annul, 1);
    step();
    chk("flush_drained", {busy, dif.annul}, 2'b00);
    chk("flush_annul_cnt", annul_cnt, 2);
    chk("flush_no_we", we_cnt, 0);
    run_div("post_flush_9_3", DIVU_CONTROL, 32'd9, 32'd3, 32'd3, 32'd0, 37);

    // Back-to-back: second request in the cycle right after WB
    run_div("b2b_9_3", DIVU_CONTROL, 32'd9, 32'd3, 32'd3, 32'd0, 37);
    run_div("b2b_10_4", DIVU_CONTROL, 32'd10, 32'd4, 32'd2, 32'd2, 37);

    // Flush in the same cycle as ready: flush wins
    clr_mon();
    accept_req(DIVU_CONTROL, 32'd100, 32'd7);
    step();
    req_valid = 1'b0;
    g = 0;
    while (!dif.ready && g < 100) begin step(); g++; end
    chk("fr_ready_seen", g < 100, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fr_abort", {hilo_we, dif.annul}, 2'b01);
    step(); step();
    chk("fr_no_we", we_cnt, 0);
    chk("fr_idle", busy, 0);

    // Flush during WB: write still completes
    clr_mon();
    accept_req(DIVU_CONTROL, 32'd100, 32'd7);
    step();
    req_valid = 1'b0;
    g = 0;
    while (!hilo_we && g < 100) begin step(); g++; end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fwb_we", we_cnt, 1);
    chk("fwb_result", {hi, lo}, {32'd2, 32'd14});

    // Reset mid-divide clears everything at once
    accept_req(DIVU_CONTROL, 32'd100, 32'd7);
    step();
    req_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst", {busy, stall, dif.start, dif.annul}, 4'b0000);
    step();

    // Fast-path candidates: identical results, shorter latency when enabled
    run_div("fast_min_1", DIV_CONTROL, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, fast_lat);
`ifdef DIV_FASTPATH_EN
    chk("fast_no_start", start_cnt, 0);
`endif
    run_div("fast_0_5", DIVU_CONTROL, 32'd0, 32'd5, 32'd0, 32'd0, fast_lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
